// File: rtl/lab_datapath.sv
// Execution datapath for the lab CPU: IR, 8-entry register file, A/B/C registers,
// shifter, ALU and status flags. All state changes are driven by controller strobes.
module lab_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             load_ir,
    input  logic [2:0]       nsel,
    input  logic             write,
    input  logic             loada,
    input  logic             loadb,
    input  logic             loadc,
    input  logic             loads,
    input  logic             asel,
    input  logic             bsel,
    input  logic [1:0]       vsel,
    input  logic [WIDTH-1:0] mdata,
    output logic [2:0]       opcode,
    output logic [1:0]       op,
    output logic [WIDTH-1:0] datapath_out,
    output logic [2:0]       status
);
    localparam int RW = $clog2(NREGS);

    logic [WIDTH-1:0]            ir, a, b, c;
    logic [NREGS-1:0][WIDTH-1:0] rf;
    logic [2:0]                  st;

    logic [RW-1:0]    num;
    logic             wr_ok;
    logic [WIDTH-1:0] rdata, wdata, sximm5, sximm8, bsh, ain, bin, res;
    logic             ovf;

    // A non-one-hot select reads R0 and blocks the write.
    always_comb begin
        num   = '0;
        wr_ok = 1'b1;
        case (nsel)
            3'b100:  num = ir[10:8];
            3'b010:  num = ir[7:5];
            3'b001:  num = ir[2:0];
            default: wr_ok = 1'b0;
        endcase
    end

    assign rdata  = rf[num];
    assign sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};

    always_comb begin
        case (vsel)
            2'b00:   wdata = c;
            2'b01:   wdata = sximm8;
            2'b10:   wdata = mdata;
            default: wdata = '0;
        endcase
    end

    always_comb begin
        case (ir[4:3])
            2'b00:   bsh = b;
            2'b01:   bsh = {b[WIDTH-2:0], 1'b0};
            2'b10:   bsh = {1'b0, b[WIDTH-1:1]};
            default: bsh = {b[WIDTH-1], b[WIDTH-1:1]};
        endcase
    end

    assign ain = asel ? '0 : a;
    assign bin = bsel ? sximm5 : bsh;

    always_comb begin
        ovf = 1'b0;
        case (ir[12:11])
            2'b00: begin
                res = ain + bin;
                ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b01: begin
                res = ain - bin;
                ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
            end
            2'b10:   res = ain & bin;
            default: res = ~bin;
        endcase
    end

    // Register-file reads see pre-edge contents, so A/B take the old value on a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
            rf <= '0;
            a  <= '0;
            b  <= '0;
            c  <= '0;
            st <= '0;
        end else begin
            if (load_ir)        ir      <= instr_in;
            if (write && wr_ok) rf[num] <= wdata;
            if (loada)          a       <= rdata;
            if (loadb)          b       <= rdata;
            if (loadc)          c       <= res;
            if (loads)          st      <= {(res == '0), res[WIDTH-1], ovf};
        end
    end

    assign opcode       = ir[15:13];
    assign op           = ir[12:11];
    assign datapath_out = c;
    assign status       = st;
endmodule

// File: tb/tb_lab_datapath.sv
// Bench for lab_datapath: directed scenarios plus randomized strobes against a
// behavioural model that works in signed integer arithmetic.
module tb_lab_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        load_ir;
    logic [2:0]  nsel;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel;
    logic [15:0] mdata;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [15:0] datapath_out;
    logic [2:0]  status;

    int nvec = 0;
    int nbad = 0;

    lab_datapath #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .load_ir(load_ir), .nsel(nsel),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .mdata(mdata), .opcode(opcode), .op(op),
        .datapath_out(datapath_out), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        reset;
        logic [15:0] instr;
        logic        load_ir;
        logic [2:0]  nsel;
        logic        write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0]  vsel;
        logic [15:0] mdata;
    } ctl_t;

    // Architectural model state
    logic [15:0] m_ir, m_a, m_b, m_c;
    logic [15:0] m_r [8];
    logic [2:0]  m_st;

    function automatic int sgn(input logic [15:0] x);
        return int'(x) - (x[15] ? 65536 : 0);
    endfunction

    // Drive one cycle of strobes and advance the model by the same cycle.
    task automatic step(input ctl_t k);
        logic [15:0] rv, bv, ain, bin, res, sx5, sx8, wv;
        int full, num;
        bit ok, v;
        @(negedge clk);
        reset = k.reset; instr_in = k.instr; load_ir = k.load_ir; nsel = k.nsel;
        write = k.write; loada = k.loada; loadb = k.loadb; loadc = k.loadc;
        loads = k.loads; asel = k.asel; bsel = k.bsel; vsel = k.vsel; mdata = k.mdata;

        ok = 1'b1; num = 0;
        case (k.nsel)
            3'b100:  num = int'(m_ir[10:8]);
            3'b010:  num = int'(m_ir[7:5]);
            3'b001:  num = int'(m_ir[2:0]);
            default: ok = 1'b0;
        endcase
        rv = m_r[num];
        case (m_ir[4:3])
            2'd0:    bv = m_b;
            2'd1:    bv = 16'(int'(m_b) * 2);
            2'd2:    bv = 16'(int'(m_b) / 2);
            default: bv = 16'(sgn(m_b) >>> 1);
        endcase
        sx5 = 16'(int'(m_ir[4:0]) - (m_ir[4] ? 32 : 0));
        sx8 = 16'(int'(m_ir[7:0]) - (m_ir[7] ? 256 : 0));
        ain = k.asel ? 16'h0000 : m_a;
        bin = k.bsel ? sx5 : bv;
        v = 1'b0;
        case (m_ir[12:11])
            2'd0:    begin full = sgn(ain) + sgn(bin); v = (full > 32767) || (full < -32768); end
            2'd1:    begin full = sgn(ain) - sgn(bin); v = (full > 32767) || (full < -32768); end
            2'd2:    full = int'(ain & bin);
            default: full = int'(~bin);
        endcase
        res = 16'(full);
        case (k.vsel)
            2'd0:    wv = m_c;
            2'd1:    wv = sx8;
            2'd2:    wv = k.mdata;
            default: wv = 16'h0000;
        endcase

        if (k.reset) begin
            m_ir = '0; m_a = '0; m_b = '0; m_c = '0; m_st = '0;
            for (int i = 0; i < 8; i++) m_r[i] = '0;
        end else begin
            if (k.load_ir)      m_ir = k.instr;
            if (k.write && ok)  m_r[num] = wv;
            if (k.loada)        m_a = rv;
            if (k.loadb)        m_b = rv;
            if (k.loadc)        m_c = res;
            if (k.loads)        m_st = {res == 16'h0000, res[15], v};
        end
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t idle();
        ctl_t k;
        k = '0;
        return k;
    endfunction

    task automatic ld_ir(input logic [15:0] w);
        ctl_t k;
        k = idle(); k.load_ir = 1'b1; k.instr = w;
        step(k);
    endtask

    task automatic strobe(input logic [2:0] ns, input bit wr, input bit la, input bit lb,
                          input bit lc, input bit ls, input bit as, input bit bs,
                          input logic [1:0] vs, input logic [15:0] md);
        ctl_t k;
        k = idle();
        k.nsel = ns; k.write = wr; k.loada = la; k.loadb = lb; k.loadc = lc;
        k.loads = ls; k.asel = as; k.bsel = bs; k.vsel = vs; k.mdata = md;
        step(k);
    endtask

    // Route R[x] to C as 0 + (B unshifted); disturbs only IR, B and C.
    task automatic peek(input int x, output logic [15:0] val);
        ld_ir({3'b101, 2'b00, 3'b000, 3'b000, 2'b00, 3'(x)});
        strobe(3'b001, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b000, 0, 0, 0, 1, 0, 1, 0, 2'b00, 16'h0);
        val = datapath_out;
    endtask

    task automatic test_reset();
        ctl_t k;
        logic [15:0] v;
        k = '1;
        k.mdata = 16'hFFFF;
        step(k);
        nvec++; if (opcode !== 3'b000) begin nbad++; $display("FAIL reset_opcode: got %b expected 000", opcode); end
        nvec++; if (op !== 2'b00) begin nbad++; $display("FAIL reset_op: got %b expected 00", op); end
        nvec++; if (datapath_out !== 16'h0000) begin nbad++; $display("FAIL reset_c: got %h expected 0000", datapath_out); end
        nvec++; if (status !== 3'b000) begin nbad++; $display("FAIL reset_status: got %b expected 000", status); end
        for (int i = 0; i < 8; i++) begin
            peek(i, v);
            nvec++; if (v !== 16'h0000) begin nbad++; $display("FAIL reset_r%0d: got %h expected 0000", i, v); end
        end
    endtask

    task automatic test_mov();
        logic [15:0] v;
        ld_ir(16'hD007);
        nvec++; if (opcode !== 3'b110 || op !== 2'b10) begin nbad++; $display("FAIL ir_fields: got %b/%b expected 110/10", opcode, op); end
        strobe(3'b100, 1, 0, 0, 0, 0, 0, 0, 2'b01, 16'h0);
        peek(0, v);
        nvec++; if (v !== 16'h0007) begin nbad++; $display("FAIL mov_r0: got %h expected 0007", v); end
        ld_ir(16'hD180);
        strobe(3'b100, 1, 0, 0, 0, 0, 0, 0, 2'b01, 16'h0);
        peek(1, v);
        nvec++; if (v !== 16'hFF80) begin nbad++; $display("FAIL mov_r1_neg: got %h expected ff80", v); end
    endtask

    task automatic test_add_shift();
        logic [15:0] v;
        ld_ir(16'hD007); strobe(3'b100, 1, 0, 0, 0, 0, 0, 0, 2'b01, 16'h0);
        ld_ir(16'hD102); strobe(3'b100, 1, 0, 0, 0, 0, 0, 0, 2'b01, 16'h0);
        ld_ir(16'hA048);
        strobe(3'b100, 0, 1, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b001, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b000, 0, 0, 0, 1, 1, 0, 0, 2'b00, 16'h0);
        nvec++; if (datapath_out !== 16'h0015) begin nbad++; $display("FAIL add_shift_c: got %h expected 0015", datapath_out); end
        nvec++; if (status !== 3'b000) begin nbad++; $display("FAIL add_shift_status: got %b expected 000", status); end
        strobe(3'b010, 1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        peek(2, v);
        nvec++; if (v !== 16'h0015) begin nbad++; $display("FAIL add_shift_r2: got %h expected 0015", v); end
    endtask

    task automatic test_overflow();
        ld_ir(16'hD300);
        strobe(3'b100, 1, 0, 0, 0, 0, 0, 0, 2'b10, 16'h7FFF);
        ld_ir(16'hA301);
        strobe(3'b100, 0, 1, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b000, 0, 0, 0, 1, 1, 0, 1, 2'b00, 16'h0);
        nvec++; if (datapath_out !== 16'h8000) begin nbad++; $display("FAIL ovf_c: got %h expected 8000", datapath_out); end
        nvec++; if (status !== 3'b011) begin nbad++; $display("FAIL ovf_status: got %b expected 011", status); end
        ld_ir(16'hAB03);
        strobe(3'b100, 0, 1, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b001, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b000, 0, 0, 0, 1, 1, 0, 0, 2'b00, 16'h0);
        nvec++; if (datapath_out !== 16'h0000) begin nbad++; $display("FAIL sub_eq_c: got %h expected 0000", datapath_out); end
        nvec++; if (status !== 3'b100) begin nbad++; $display("FAIL sub_eq_status: got %b expected 100", status); end
    endtask

    task automatic test_same_cycle();
        ld_ir(16'hC400);
        strobe(3'b100, 1, 1, 0, 0, 0, 0, 0, 2'b10, 16'h1234);
        strobe(3'b000, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h0);
        nvec++; if (datapath_out !== 16'h0000) begin nbad++; $display("FAIL same_cycle_old: got %h expected 0000", datapath_out); end
        strobe(3'b100, 0, 1, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b000, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h0);
        nvec++; if (datapath_out !== 16'h1234) begin nbad++; $display("FAIL same_cycle_new: got %h expected 1234", datapath_out); end
    endtask

    task automatic test_mid_reset();
        ctl_t k;
        logic [15:0] v;
        ld_ir(16'hD005); strobe(3'b100, 1, 0, 0, 0, 0, 0, 0, 2'b01, 16'h0);
        ld_ir(16'hA048);
        strobe(3'b100, 0, 1, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        strobe(3'b001, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h0);
        k = idle(); k.reset = 1'b1; step(k);
        strobe(3'b000, 0, 0, 0, 1, 1, 0, 0, 2'b00, 16'h0);
        nvec++; if (datapath_out !== 16'h0000) begin nbad++; $display("FAIL mid_reset_c: got %h expected 0000", datapath_out); end
        nvec++; if (status !== 3'b100) begin nbad++; $display("FAIL mid_reset_status: got %b expected 100", status); end
        strobe(3'b010, 1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0);
        peek(2, v);
        nvec++; if (v !== 16'h0000) begin nbad++; $display("FAIL mid_reset_r2: got %h expected 0000", v); end
    endtask

    task automatic test_random();
        ctl_t k;
        logic [15:0] v;
        for (int n = 0; n < 400; n++) begin
            k = ctl_t'({$urandom, $urandom});
            k.reset = ($urandom_range(0, 40) == 0);
            step(k);
            nvec++;
            if (opcode !== m_ir[15:13] || op !== m_ir[12:11] || datapath_out !== m_c || status !== m_st) begin
                nbad++;
                $display("FAIL rand_%0d: got op=%b/%b c=%h st=%b expected op=%b/%b c=%h st=%b",
                         n, opcode, op, datapath_out, status, m_ir[15:13], m_ir[12:11], m_c, m_st);
            end
        end
        for (int i = 0; i < 8; i++) begin
            peek(i, v);
            nvec++; if (v !== m_r[i]) begin nbad++; $display("FAIL rand_r%0d: got %h expected %h", i, v, m_r[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; instr_in = '0; load_ir = 0; nsel = '0; write = 0; loada = 0;
        loadb = 0; loadc = 0; loads = 0; asel = 0; bsel = 0; vsel = '0; mdata = '0;
        m_ir = '0; m_a = '0; m_b = '0; m_c = '0; m_st = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        test_reset();
        test_mov();
        test_add_shift();
        test_overflow();
        test_same_cycle();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/lab_datapath.md
Name: lab_datapath

Overview:
- Execution datapath driven by the lab CPU control state machine. It is the responder end of the controller's control bus.
- Holds the instruction register, which supplies opcode and op back to the controller.
- Contains the 8x16 register file, the A/B/C pipeline registers, the shifter, the ALU and the status flags.
- Every register update happens only on a controller strobe. The block never sequences itself.

Parameters:
- WIDTH, 16, datapath word width. All behaviour below is specified for 16.
- NREGS, 8, number of general registers. Fixed at 8 because nsel encodes 3-bit register fields.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- instr_in  input  16  instruction word presented to the IR
- load_ir  input  1  capture instr_in into the IR
- nsel  input  3  register field select: 100=Rn, 010=Rd, 001=Rm
- write  input  1  register file write enable
- loada  input  1  load A register
- loadb  input  1  load B register
- loadc  input  1  load C register
- loads  input  1  load status flags
- asel  input  1  1: ALU A input is 0; 0: A register
- bsel  input  1  1: ALU B input is sximm5; 0: shifted B register
- vsel  input  2  write-back source: 00=C, 01=sximm8, 10=mdata, 11=16'h0000
- mdata  input  16  external memory data for write-back
- opcode  output  3  IR[15:13], to controller
- op  output  2  IR[12:11], to controller
- datapath_out  output  16  contents of C
- status  output  3  {Z,N,V}

Behaviour:
- Reset: when reset=1 at a rising edge, all of the following clear to 0:
  - IR, R0..R7, A, B, C, status.
  - Consequently opcode=000, op=00, datapath_out=0, status=000 from that edge on.
  - Reset dominates every load/write strobe asserted in the same cycle.
  - Reset mid-instruction discards all partial state.
- IR:
  - IR <= instr_in on an edge with load_ir=1; otherwise it holds.
  - Instruction fields: Rn=IR[10:8], Rd=IR[7:5], shift=IR[4:3], Rm=IR[2:0].
  - sximm8 = IR[7:0] sign-extended. sximm5 = IR[4:0] sign-extended.
- Register number select:
  - nsel picks Rn, Rd or Rm as the common read/write number.
  - Any nsel value that is not one-hot: read returns R0, and any write that cycle is suppressed.
- Register file:
  - Reads are combinational on the selected number.
  - Writes are synchronous: R[num] <= vsel-selected value when write=1.
  - Write and loada/loadb in the same cycle on the same register: A/B capture the OLD value. The new value is visible from the next cycle.
- A and B registers: A <= read data on loada; B <= read data on loadb. Both strobes together load both registers.
- Shifter (applied to B; shift field from the IR):
  - 00: pass through.
  - 01: shift left 1, zero fill.
  - 10: logical shift right 1, MSB = 0.
  - 11: arithmetic shift right 1, MSB preserved.
- ALU operands: Ain = asel ? 0 : A. Bin = bsel ? sximm5 : shifted B. The ALU function is selected by op.
- ALU functions:
  - 00: Ain + Bin, modulo 2^16.
  - 01: Ain - Bin, modulo 2^16.
  - 10: Ain & Bin.
  - 11: ~Bin.
- C register: C <= ALU result when loadc=1.
- Status (loaded from the current ALU result when loads=1):
  - Z = (result == 0).
  - N = result[15].
  - V for add: set when both operands have the same sign and the result sign differs.
  - V for sub: set when the operands have different signs and the result sign differs from Ain.
  - V = 0 for AND and NOT.
- Latency: an ALU instruction under controller sequencing takes 4 cycles:
  - loada, then loadb, then loadc (and loads), then write with vsel=00.
  - The result is architecturally visible in the destination register on the edge after that write cycle.

Test Plan:
- Reset: apply reset 1 cycle with every strobe high and mdata=16'hFFFF -> all registers 0, status=000, opcode=000, op=00.
- MOV immediate:
  - IR=16'hD007 (opcode 110, op 10, Rn=0, imm8=07); write, nsel=100, vsel=01 -> R0=16'h0007.
  - IR with imm8=8'h80 into R1 -> R1=16'hFF80.
- ADD with shift:
  - Preload R0=7, R1=2. IR=16'hA048 (opcode 101, op 00, Rn=0, Rd=2, shift 01, Rm=0). Note Rn=R0 here.
  - Run the loada(nsel=100) / loadb(nsel=001) / loadc+loads / write(nsel=010, vsel=00) sequence.
  - Result: R2 = 7 + 14 = 16'h0015, status=000.
- Overflow:
  - Load R3=16'h7FFF via vsel=10 from mdata. ADD with Ain=R3, bsel=1, sximm5=1.
  - Result: C=16'h8000, status Z=0, N=1, V=1.
  - SUB with equal operands -> Z=1, N=0, V=0.
- Same-cycle write/read: write R4=16'h1234 with loada=1 on nsel selecting R4 (previously 0) -> A=0. A reload next cycle gives 16'h1234.
- Mid-operation reset: assert reset after loadb in an ADD sequence, then complete the strobes -> destination register stays 0 and C=0.
